// File: rtl/tagged_stream_partitioner_if.sv
// Stream interfaces for the partitioner: ntagged_i carries NUM_TUPLES tuples plus a hash tag per
// lane; ndata_i carries plain tuples. Both use valid/ready with per-lane keep and a last marker.
interface ntagged_i #(
  parameter type         tuple_t    = logic [31:0],
  parameter int unsigned NUM_TUPLES = 4,
  parameter int unsigned HASH_WIDTH = 16
);
  tuple_t                  data [NUM_TUPLES];
  logic [HASH_WIDTH-1:0]   tag  [NUM_TUPLES];
  logic [NUM_TUPLES-1:0]   keep;
  logic                    last;
  logic                    valid;
  logic                    ready;

  modport m (output data, tag, keep, last, valid, input ready);
  modport s (input data, tag, keep, last, valid, output ready);
endinterface

interface ndata_i #(
  parameter type         tuple_t    = logic [31:0],
  parameter int unsigned NUM_TUPLES = 1
);
  tuple_t                  data [NUM_TUPLES];
  logic [NUM_TUPLES-1:0]   keep;
  logic                    last;
  logic                    valid;
  logic                    ready;

  modport m (output data, keep, last, valid, input ready);
  modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/tagged_stream_partitioner.sv
// Serialises the kept lanes of each tagged beat and routes them by tag to one of NUM_PARTITIONS
// single-tuple streams. Define PARTITIONER_STATS_EN to add per-partition emitted-tuple counters.
module tagged_stream_partitioner #(
  parameter type         tuple_t        = logic [31:0],
  parameter int unsigned NUM_TUPLES     = 4,
  parameter int unsigned HASH_WIDTH     = 16,
  parameter int unsigned NUM_PARTITIONS = 8
) (
  input  logic clk,
  input  logic rst_n,
  ntagged_i.s  in,
  ndata_i.m    out [NUM_PARTITIONS]
`ifdef PARTITIONER_STATS_EN
  ,
  output logic [31:0] stat_cnt [NUM_PARTITIONS]
`endif
);

  localparam int unsigned PART_BITS = $clog2(NUM_PARTITIONS);
  localparam int unsigned LANE_BITS = (NUM_TUPLES > 1) ? $clog2(NUM_TUPLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FLUSH
  } state_t;

  state_t                    state, state_nx;
  logic [NUM_TUPLES-1:0]     pending, pending_nx;
  logic [NUM_PARTITIONS-1:0] done, done_nx;

  tuple_t                    lane_data [NUM_TUPLES];
  logic [PART_BITS-1:0]      lane_part [NUM_TUPLES];
  logic [NUM_TUPLES-1:0]     unused_tag_fold;

  logic [NUM_PARTITIONS-1:0] reg_valid;
  logic [NUM_PARTITIONS-1:0] reg_keep;
  logic [NUM_PARTITIONS-1:0] reg_last;
  logic [NUM_PARTITIONS-1:0] reg_ready;
  tuple_t                    reg_data [NUM_PARTITIONS];
  logic [NUM_PARTITIONS-1:0] can_load;
  logic [NUM_PARTITIONS-1:0] load;

  tuple_t                    ld_data;
  logic                      ld_keep;
  logic                      ld_last;
  logic [LANE_BITS-1:0]      sel_lane;
  logic                      sel_found;
  logic [PART_BITS-1:0]      sel_part;
  logic                      in_ready;

  for (genvar i = 0; i < NUM_TUPLES; i++) begin : g_lane
    assign lane_data[i]       = in.data[i];
    assign lane_part[i]       = in.tag[i][PART_BITS-1:0];
    // Only the low tag bits select a partition; the rest are deliberately ignored.
    assign unused_tag_fold[i] = ^in.tag[i];
  end

  for (genvar g = 0; g < NUM_PARTITIONS; g++) begin : g_part
    assign out[g].valid   = reg_valid[g];
    assign out[g].keep[0] = reg_keep[g];
    assign out[g].last    = reg_last[g];
    assign out[g].data[0] = reg_data[g];
    assign reg_ready[g]   = out[g].ready;
  end

  assign can_load = ~reg_valid | reg_ready;
  assign in.ready = in_ready & rst_n;

  always_comb begin
    sel_found = 1'b0;
    sel_lane  = '0;
    for (int unsigned i = 0; i < NUM_TUPLES; i++) begin
      if (!sel_found && pending[i]) begin
        sel_found = 1'b1;
        sel_lane  = LANE_BITS'(i);
      end
    end
    sel_part = lane_part[sel_lane];
  end

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    done_nx    = done;
    load       = '0;
    ld_data    = '0;
    ld_keep    = 1'b0;
    ld_last    = 1'b0;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (in.valid) begin
          pending_nx = in.keep;
          if (in.keep == '0) begin
            in_ready = 1'b1;
            state_nx = in.last ? FLUSH : IDLE;
          end else begin
            state_nx = SCAN;
          end
        end
      end
      SCAN: begin
        // Strictly in lane order: a blocked lane stalls later lanes to keep per-partition order.
        if (sel_found && can_load[sel_part]) begin
          load[sel_part]       = 1'b1;
          ld_data              = lane_data[sel_lane];
          ld_keep              = 1'b1;
          pending_nx[sel_lane] = 1'b0;
          if (pending_nx == '0) begin
            in_ready = 1'b1;
            state_nx = in.last ? FLUSH : IDLE;
          end
        end
      end
      FLUSH: begin
        load    = ~done & can_load;
        ld_last = 1'b1;
        done_nx = done | load;
        if (&done_nx) begin
          done_nx  = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      done    <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      done    <= done_nx;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NUM_PARTITIONS; p++) begin
      if (!rst_n) begin
        reg_valid[p] <= 1'b0;
        reg_keep[p]  <= 1'b0;
        reg_last[p]  <= 1'b0;
        reg_data[p]  <= '0;
      end else if (load[p]) begin
        reg_valid[p] <= 1'b1;
        reg_keep[p]  <= ld_keep;
        reg_last[p]  <= ld_last;
        reg_data[p]  <= ld_data;
      end else if (reg_valid[p] && reg_ready[p]) begin
        reg_valid[p] <= 1'b0;
      end
    end
  end

`ifdef PARTITIONER_STATS_EN
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NUM_PARTITIONS; p++) begin
      if (!rst_n) begin
        stat_cnt[p] <= '0;
      end else if (reg_valid[p] && reg_ready[p] && reg_keep[p]) begin
        stat_cnt[p] <= stat_cnt[p] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tagged_stream_partitioner.sv
// Directed self-checking bench for tagged_stream_partitioner (8 partitions, 4 lanes, 16-bit tags).
module tb_tagged_stream_partitioner;

  localparam int unsigned NP = 8;
  localparam int unsigned NT = 4;
  localparam int unsigned HW = 16;

  typedef logic [31:0] tuple_t;
  typedef struct packed {
    logic [31:0] cyc;
    logic        keep;
    logic        last;
    logic [31:0] data;
  } ev_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntagged_i #(.tuple_t(tuple_t), .NUM_TUPLES(NT), .HASH_WIDTH(HW)) in_if ();
  ndata_i   #(.tuple_t(tuple_t), .NUM_TUPLES(1))                  out_if [NP] ();

  logic [NP-1:0] ordy;
  logic [NP-1:0] ov, ok, ol;
  tuple_t        od [NP];

`ifdef PARTITIONER_STATS_EN
  logic [31:0] stat_cnt [NP];
`endif

  tagged_stream_partitioner #(
    .tuple_t(tuple_t), .NUM_TUPLES(NT), .HASH_WIDTH(HW), .NUM_PARTITIONS(NP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in_if),
    .out(out_if)
`ifdef PARTITIONER_STATS_EN
    ,
    .stat_cnt(stat_cnt)
`endif
  );

  for (genvar g = 0; g < NP; g++) begin : g_mirror
    assign ov[g] = out_if[g].valid;
    assign ok[g] = out_if[g].keep[0];
    assign ol[g] = out_if[g].last;
    assign od[g] = out_if[g].data[0];
    assign out_if[g].ready = ordy[g];
  end

  ev_t         ev_q [NP][$];
  int unsigned in_hs_q [$];
  int unsigned base [NP];
  int unsigned hs_base;

  always @(posedge clk) begin
    for (int p = 0; p < NP; p++)
      if (ov[p] && ordy[p]) ev_q[p].push_back({cyc, ok[p], ol[p], od[p]});
    if (in_if.valid && in_if.ready) in_hs_q.push_back(cyc);
  end

  function automatic int n_ev(input int p);
    return ev_q[p].size() - base[p];
  endfunction

  function automatic ev_t ev(input int p, input int k);
    return ev_q[p][base[p] + k];
  endfunction

  function automatic int n_hs();
    return in_hs_q.size() - hs_base;
  endfunction

  task automatic mark_logs();
    for (int p = 0; p < NP; p++) base[p] = ev_q[p].size();
    hs_base = in_hs_q.size();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [NT-1:0] keep, input logic last,
                            input logic [NT*HW-1:0] tags, input logic [NT*32-1:0] data);
    for (int i = 0; i < NT; i++) begin
      in_if.tag[i]  = tags[i*HW +: HW];
      in_if.data[i] = data[i*32 +: 32];
    end
    in_if.keep  = keep;
    in_if.last  = last;
    in_if.valid = 1'b1;
  endtask

  // Waits for in.ready (sampled mid-cycle), completes the handshake, then drops valid.
  task automatic wait_accept(input int unsigned budget, output int unsigned waited);
    logic got;
    got    = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge clk);
      if (in_if.ready) got = 1'b1;
      else waited++;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL accept_timeout: in.ready never seen within %0d cycles", budget);
    end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    in_if.valid = 1'b0;
    ordy        = '1;
    repeat (2) tick();
    n_checks++;
    if (in_if.ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_if.ready);
    end
    n_checks++;
    if ({ov, ok, ol} !== '0) begin
      n_fail++; $display("FAIL reset_out_ctrl: valid=%b keep=%b last=%b expected all 0", ov, ok, ol);
    end
    for (int p = 0; p < NP; p++) begin
      n_checks++;
      if (od[p] !== 32'h0) begin
        n_fail++; $display("FAIL reset_out_data[%0d]: got %h expected 0", p, od[p]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_distinct_lanes();
    int unsigned w;
    mark_logs();
    ordy = '1;
    drive_beat(4'b1111, 1'b0, {16'd3, 16'd2, 16'd1, 16'd0},
               {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    wait_accept(20, w);
    repeat (3) tick();
    n_checks++;
    if (w !== 4) begin
      n_fail++; $display("FAIL distinct_accept_latency: got %0d cycles expected 4", w);
    end
    n_checks++;
    if (n_hs() !== 1) begin
      n_fail++; $display("FAIL distinct_in_handshakes: got %0d expected 1", n_hs());
    end
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (n_ev(p) !== 1) begin
        n_fail++; $display("FAIL distinct_count[%0d]: got %0d expected 1", p, n_ev(p));
      end else begin
        n_checks++;
        if ({ev(p, 0).keep, ev(p, 0).last, ev(p, 0).data} !== {1'b1, 1'b0, 32'hA0 + p}) begin
          n_fail++;
          $display("FAIL distinct_beat[%0d]: got k=%b l=%b d=%h expected k=1 l=0 d=%h",
                   p, ev(p, 0).keep, ev(p, 0).last, ev(p, 0).data, 32'hA0 + p);
        end
        n_checks++;
        if (n_hs() == 1 && ev(p, 0).cyc !== in_hs_q[hs_base] + p - 2) begin
          n_fail++;
          $display("FAIL distinct_timing[%0d]: got cycle %0d expected %0d",
                   p, ev(p, 0).cyc, in_hs_q[hs_base] + p - 2);
        end
      end
    end
    for (int p = 4; p < NP; p++) begin
      n_checks++;
      if (n_ev(p) !== 0) begin
        n_fail++; $display("FAIL distinct_idle[%0d]: got %0d beats expected 0", p, n_ev(p));
      end
    end
  endtask

  task automatic test_shared_partition();
    int unsigned w;
    int          others;
    mark_logs();
    ordy    = '1;
    ordy[5] = 1'b0;
    drive_beat(4'b1010, 1'b0, {4{16'd5}}, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (in_if.ready !== 1'b0) begin
        n_fail++; $display("FAIL shared_stall_ready: got %b expected 0", in_if.ready);
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if ({ov[5], od[5]} !== {1'b1, 32'hB1}) begin
      n_fail++; $display("FAIL shared_held: got v=%b d=%h expected v=1 d=b1", ov[5], od[5]);
    end
    ordy[5] = 1'b1;
    wait_accept(10, w);
    repeat (3) tick();
    n_checks++;
    if (w !== 0) begin
      n_fail++; $display("FAIL shared_release_latency: got %0d expected 0", w);
    end
    n_checks++;
    if (n_ev(5) !== 2) begin
      n_fail++; $display("FAIL shared_count: got %0d expected 2", n_ev(5));
    end else begin
      n_checks++;
      if ({ev(5, 0).data, ev(5, 1).data} !== {32'hB1, 32'hB3}) begin
        n_fail++;
        $display("FAIL shared_order: got %h,%h expected b1,b3", ev(5, 0).data, ev(5, 1).data);
      end
    end
    others = 0;
    for (int p = 0; p < NP; p++) if (p != 5) others += n_ev(p);
    n_checks++;
    if (others !== 0) begin
      n_fail++; $display("FAIL shared_others: got %0d beats expected 0", others);
    end
  endtask

  task automatic test_last_flush();
    int unsigned w;
    mark_logs();
    ordy = '1;
    // Tag ABCA: only the low 3 bits (2) select the partition.
    drive_beat(4'b0001, 1'b1, {16'h0, 16'h0, 16'h0, 16'hABCA}, {32'h0, 32'h0, 32'h0, 32'hC0});
    wait_accept(10, w);
    drive_beat(4'b0001, 1'b0, {16'h0, 16'h0, 16'h0, 16'h0001}, {32'h0, 32'h0, 32'h0, 32'hC1});
    wait_accept(30, w);
    repeat (3) tick();
    n_checks++;
    if (n_ev(2) !== 2) begin
      n_fail++; $display("FAIL flush_p2_count: got %0d expected 2", n_ev(2));
    end else begin
      n_checks++;
      if ({ev(2, 0).keep, ev(2, 0).last, ev(2, 0).data, ev(2, 1).keep, ev(2, 1).last}
          !== {1'b1, 1'b0, 32'hC0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL flush_p2_seq: got k=%b l=%b d=%h then k=%b l=%b expected 1 0 c0 then 0 1",
                 ev(2, 0).keep, ev(2, 0).last, ev(2, 0).data, ev(2, 1).keep, ev(2, 1).last);
      end
    end
    n_checks++;
    if (n_ev(1) !== 2) begin
      n_fail++; $display("FAIL flush_p1_count: got %0d expected 2", n_ev(1));
    end else begin
      n_checks++;
      if ({ev(1, 0).keep, ev(1, 0).last, ev(1, 1).keep, ev(1, 1).last, ev(1, 1).data}
          !== {1'b0, 1'b1, 1'b1, 1'b0, 32'hC1}) begin
        n_fail++;
        $display("FAIL flush_p1_seq: got k=%b l=%b then k=%b l=%b d=%h expected 0 1 then 1 0 c1",
                 ev(1, 0).keep, ev(1, 0).last, ev(1, 1).keep, ev(1, 1).last, ev(1, 1).data);
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (p != 1 && p != 2) begin
        n_checks++;
        if (n_ev(p) !== 1 || {ev(p, 0).keep, ev(p, 0).last} !== 2'b01) begin
          n_fail++;
          $display("FAIL flush_beat[%0d]: got %0d beats k=%b l=%b expected 1 beat k=0 l=1",
                   p, n_ev(p), ev(p, 0).keep, ev(p, 0).last);
        end
      end
    end
    n_checks++;
    if (n_hs() !== 2) begin
      n_fail++; $display("FAIL flush_in_handshakes: got %0d expected 2", n_hs());
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (n_ev(p) >= 1) begin
          n_checks++;
          if (in_hs_q[hs_base + 1] <= ev(p, p == 2 ? 1 : 0).cyc) begin
            n_fail++;
            $display("FAIL flush_ready_early[%0d]: next beat taken at %0d, flush beat at %0d",
                     p, in_hs_q[hs_base + 1], ev(p, p == 2 ? 1 : 0).cyc);
          end
        end
      end
    end
  endtask

  task automatic test_empty_beats();
    int unsigned w;
    int          total;
    mark_logs();
    ordy = '1;
    drive_beat(4'b0000, 1'b0, '0, '0);
    wait_accept(10, w);
    repeat (3) tick();
    n_checks++;
    if (w !== 0) begin
      n_fail++; $display("FAIL empty_accept_latency: got %0d expected 0", w);
    end
    total = 0;
    for (int p = 0; p < NP; p++) total += n_ev(p);
    n_checks++;
    if (total !== 0) begin
      n_fail++; $display("FAIL empty_no_output: got %0d beats expected 0", total);
    end
    mark_logs();
    drive_beat(4'b0000, 1'b1, '0, '0);
    wait_accept(10, w);
    repeat (4) tick();
    n_checks++;
    if (w !== 0) begin
      n_fail++; $display("FAIL empty_last_latency: got %0d expected 0", w);
    end
    for (int p = 0; p < NP; p++) begin
      n_checks++;
      if (n_ev(p) !== 1 || {ev(p, 0).keep, ev(p, 0).last} !== 2'b01) begin
        n_fail++;
        $display("FAIL empty_flush[%0d]: got %0d beats k=%b l=%b expected 1 beat k=0 l=1",
                 p, n_ev(p), ev(p, 0).keep, ev(p, 0).last);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int unsigned w;
    int          others;
    mark_logs();
    ordy    = '1;
    ordy[3] = 1'b0;
    drive_beat(4'b0111, 1'b0, {16'd0, 16'd3, 16'd3, 16'd3}, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
    tick();
    tick();
    n_checks++;
    if ({ov[3], od[3]} !== {1'b1, 32'hE0}) begin
      n_fail++; $display("FAIL midscan_setup: got v=%b d=%h expected v=1 d=e0", ov[3], od[3]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (in_if.ready !== 1'b0) begin
      n_fail++; $display("FAIL midscan_in_ready: got %b expected 0", in_if.ready);
    end
    n_checks++;
    if (ov !== '0) begin
      n_fail++; $display("FAIL midscan_out_valid: got %b expected 0", ov);
    end
    in_if.valid = 1'b0;
    tick();
    mark_logs();
    ordy = '1;
    drive_beat(4'b0011, 1'b0, {16'd0, 16'd0, 16'd1, 16'd6}, {32'h0, 32'h0, 32'hF1, 32'hF0});
    wait_accept(20, w);
    repeat (3) tick();
    n_checks++;
    if (w !== 2) begin
      n_fail++; $display("FAIL midscan_new_latency: got %0d expected 2", w);
    end
    n_checks++;
    if (n_ev(6) !== 1 || ev(6, 0).data !== 32'hF0) begin
      n_fail++; $display("FAIL midscan_p6: got %0d beats d=%h expected 1 beat d=f0", n_ev(6), ev(6, 0).data);
    end
    n_checks++;
    if (n_ev(1) !== 1 || ev(1, 0).data !== 32'hF1) begin
      n_fail++; $display("FAIL midscan_p1: got %0d beats d=%h expected 1 beat d=f1", n_ev(1), ev(1, 0).data);
    end
    others = 0;
    for (int p = 0; p < NP; p++) if (p != 1 && p != 6) others += n_ev(p);
    n_checks++;
    if (others !== 0) begin
      n_fail++; $display("FAIL midscan_stale: got %0d beats expected 0", others);
    end
  endtask

`ifdef PARTITIONER_STATS_EN
  task automatic test_stats();
    int unsigned     w;
    int unsigned     ref_cnt [NP];
    int unsigned     total;
    logic [31:0]     sum;
    logic [NT-1:0]   keep;
    logic            last;
    logic [NT*HW-1:0] tags;
    logic [1:0]      t;
    rst_n       = 1'b0;
    in_if.valid = 1'b0;
    ordy        = '1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int p = 0; p < NP; p++) ref_cnt[p] = 0;
    total = 0;
    for (int b = 0; b < 100; b++) begin
      keep = NT'($urandom_range(0, 15));
      last = ($urandom_range(0, 7) == 0);
      tags = '0;
      for (int i = 0; i < NT; i++) begin
        t = 2'($urandom_range(0, 3));
        tags[i*HW +: HW] = {14'h0, t};
        if (keep[i]) begin
          ref_cnt[t]++;
          total++;
        end
      end
      drive_beat(keep, last, tags, {32'(b * 4 + 3), 32'(b * 4 + 2), 32'(b * 4 + 1), 32'(b * 4)});
      wait_accept(60, w);
    end
    repeat (5) tick();
    sum = '0;
    for (int p = 0; p < NP; p++) begin
      sum += stat_cnt[p];
      n_checks++;
      if (stat_cnt[p] !== ref_cnt[p]) begin
        n_fail++; $display("FAIL stats_cnt[%0d]: got %0d expected %0d", p, stat_cnt[p], ref_cnt[p]);
      end
    end
    n_checks++;
    if (sum !== total) begin
      n_fail++; $display("FAIL stats_sum: got %0d expected %0d", sum, total);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_if.valid = 1'b0;
    in_if.keep  = '0;
    in_if.last  = 1'b0;
    for (int i = 0; i < NT; i++) begin
      in_if.tag[i]  = '0;
      in_if.data[i] = '0;
    end
    ordy = '1;
    test_reset();
    test_distinct_lanes();
    test_shared_partition();
    test_last_flush();
    test_empty_beats();
    test_reset_mid_scan();
`ifdef PARTITIONER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
